// File: rtl/display_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : disp_pkg
//  Description : Shared state encoding and display constants for display_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package disp_pkg;

    localparam int DIGIT_W = 16;
    localparam logic [DIGIT_W-1:0] BLANK_VALUE = 16'h0000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

endpackage : disp_pkg
`default_nettype wire

// File: rtl/display_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : display_arbiter_if
//  Description : Requester/display bus of the display arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface display_arbiter_if #(
    parameter int NSRC  = 4,
    parameter int SRC_W = 2
);
    logic [NSRC-1:0]    req;
    logic [16*NSRC-1:0] data_in;
    logic               mode_auto;
    logic               step;
    logic [15:0]        digit_out;
    logic [NSRC-1:0]    grant;
    logic [SRC_W-1:0]   src_id;
    logic               blank;

    modport master (
        output req, data_in, mode_auto, step,
        input  digit_out, grant, src_id, blank
    );

    modport slave (
        input  req, data_in, mode_auto, step,
        output digit_out, grant, src_id, blank
    );
endinterface : display_arbiter_if
`default_nettype wire

// File: rtl/display_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational circular search for the next set request bit,
//                starting after i_start and visiting i_start itself last.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int NSRC  = 4,
    parameter int SRC_W = 2
) (
    input  wire logic [NSRC-1:0]  i_req,
    input  wire logic [SRC_W-1:0] i_start,
    output logic      [SRC_W-1:0] o_idx,
    output logic                  o_found
);

    always_comb begin
        logic [SRC_W-1:0] w_cand;
        o_idx   = '0;
        o_found = 1'b0;
        w_cand  = '0;
        // NSRC is a power of two, so the index wraps by truncation
        for (int i = 1; i <= NSRC; i++) begin
            w_cand = i_start + SRC_W'(i);
            if (!o_found && i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : display_arbiter
//  Description : Shares one 4-digit display among NSRC sources, rotating on a
//                dwell timer or stepping on a button pulse.
//                Option macro DISP_ARB_PRIO_EN: source 0 pre-empts all others.
//  Revision    : 1.0  initial release
// ============================================================================
module display_arbiter
    import disp_pkg::*;
#(
    parameter int NSRC         = 4,
    parameter int SRC_W        = 2,
    parameter int DWELL_CYCLES = 25_000_000,
    parameter int CNT_W        = 25
) (
    input  wire logic         clk,
    input  wire logic         rst,
    display_arbiter_if.slave  bus
);

    state_t               r_state,  w_state_nxt;
    logic [SRC_W-1:0]     r_src_id, w_src_id_nxt;
    logic [SRC_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
    logic [CNT_W-1:0]     r_cnt,    w_cnt_nxt;
    logic [DIGIT_W-1:0]   r_digit,  w_digit_nxt;

    logic [SRC_W-1:0]     w_start;
    logic [SRC_W-1:0]     w_pick_idx;
    logic                 w_pick_found;
    logic                 w_cnt_max;
    logic                 w_prio_req;
    logic                 w_prio_hold;
    logic                 w_preempt;
    logic                 w_adv;
    logic [DIGIT_W-1:0]   w_slice;
    logic [NSRC-1:0]      w_grant;

`ifdef DISP_ARB_PRIO_EN
    assign w_prio_req = bus.req[0];
`else
    assign w_prio_req = 1'b0;
`endif

    // While idle the search continues from the last shown source
    assign w_start   = (r_state == ST_SHOW) ? r_src_id : r_rr_ptr;

    rr_pick #(
        .NSRC  (NSRC),
        .SRC_W (SRC_W)
    ) u_rr_pick (
        .i_req   (bus.req),
        .i_start (w_start),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    assign w_cnt_max   = (r_cnt == CNT_W'(DWELL_CYCLES - 1));
    assign w_prio_hold = w_prio_req & (r_src_id == '0);
    assign w_preempt   = w_prio_req & (r_src_id != '0);
    assign w_slice     = bus.data_in[{r_src_id, 4'b0000} +: DIGIT_W];
    assign w_adv       = ~bus.req[r_src_id]
                       | (~w_prio_hold & (bus.step | (bus.mode_auto & w_cnt_max)));

    always_comb begin
        w_state_nxt  = r_state;
        w_src_id_nxt = r_src_id;
        w_rr_ptr_nxt = r_rr_ptr;
        w_cnt_nxt    = r_cnt;
        w_digit_nxt  = r_digit;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt  = ST_SHOW;
                    w_src_id_nxt = w_prio_req ? '0 : w_pick_idx;
                    w_cnt_nxt    = '0;
                end
            end
            ST_SHOW: begin
                w_digit_nxt = w_slice;
                if (w_preempt) begin
                    w_src_id_nxt = '0;
                    w_cnt_nxt    = '0;
                end else if (w_adv) begin
                    w_rr_ptr_nxt = r_src_id;
                    if (w_pick_found) begin
                        w_src_id_nxt = w_pick_idx;
                        w_cnt_nxt    = '0;
                    end else begin
                        w_state_nxt  = ST_IDLE;
                        w_src_id_nxt = '0;
                    end
                end else if (!w_cnt_max) begin
                    // Saturates in manual mode so a later switch to auto advances at once
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_src_id_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_src_id <= '0;
            r_rr_ptr <= SRC_W'(NSRC - 1);
            r_cnt    <= '0;
            r_digit  <= BLANK_VALUE;
        end else begin
            r_state  <= w_state_nxt;
            r_src_id <= w_src_id_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_digit  <= w_digit_nxt;
        end
    end

    always_comb begin
        w_grant = '0;
        if (r_state == ST_SHOW) begin
            w_grant[r_src_id] = 1'b1;
        end
    end

    assign bus.digit_out = r_digit;
    assign bus.grant     = w_grant;
    assign bus.src_id    = r_src_id;
    assign bus.blank     = (r_state == ST_IDLE);

endmodule : display_arbiter
`default_nettype wire

// File: tb/tb_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_arbiter
//  Description : Directed and random stimulus for display_arbiter against a
//                behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_display_arbiter;

    localparam int NSRC  = 4;
    localparam int SRC_W = 2;
    localparam int DWELL = 4;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display_arbiter_if #(.NSRC(NSRC), .SRC_W(SRC_W)) bus();

    display_arbiter #(
        .NSRC         (NSRC),
        .SRC_W        (SRC_W),
        .DWELL_CYCLES (DWELL),
        .CNT_W        (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    bit          m_show;
    int          m_cur;
    int          m_cnt;
    int          m_ptr;
    logic [15:0] m_digit;
    logic [15:0] data [NSRC];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(int i, logic [15:0] v);
        data[i] = v;
        bus.data_in[i*16 +: 16] = v;
    endtask

    function automatic int next_src(int start, logic [NSRC-1:0] r);
        for (int k = 1; k <= NSRC; k++) begin
            if (r[(start + k) % NSRC]) return (start + k) % NSRC;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [NSRC-1:0] r;
        bit adv;
        bit pre;
        bit holdp;
        r     = bus.req;
        pre   = 1'b0;
        holdp = 1'b0;
        if (rst) begin
            m_show = 1'b0; m_cur = 0; m_cnt = 0; m_ptr = NSRC - 1; m_digit = 16'h0000;
        end else if (!m_show) begin
            if (r != 0) begin
                m_cur = next_src(m_ptr, r);
`ifdef DISP_ARB_PRIO_EN
                if (r[0]) m_cur = 0;
`endif
                m_show = 1'b1;
                m_cnt  = 0;
            end
        end else begin
            m_digit = data[m_cur];
`ifdef DISP_ARB_PRIO_EN
            pre   = r[0] && (m_cur != 0);
            holdp = r[0] && (m_cur == 0);
`endif
            if (pre) begin
                m_cur = 0;
                m_cnt = 0;
            end else begin
                adv = !r[m_cur] || (!holdp && (bus.step || (bus.mode_auto && m_cnt == DWELL - 1)));
                if (adv) begin
                    m_ptr = m_cur;
                    if (r == 0) begin
                        m_show = 1'b0;
                        m_cur  = 0;
                    end else begin
                        m_cur = next_src(m_cur, r);
                        m_cnt = 0;
                    end
                end else if (m_cnt < DWELL - 1) begin
                    m_cnt++;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [NSRC-1:0] eg;
        eg = '0;
        if (m_show) eg[m_cur] = 1'b1;
        check("grant",  32'(bus.grant),  32'(eg));
        check("src_id", 32'(bus.src_id), m_show ? 32'(m_cur) : 32'd0);
        check("blank",  32'(bus.blank),  m_show ? 32'd0 : 32'd1);
        check("digit",  32'(bus.digit_out), 32'(m_digit));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        bus.req       = '0;
        bus.step      = 1'b0;
        bus.mode_auto = 1'b0;
        bus.data_in   = '0;
        for (int i = 0; i < NSRC; i++) put(i, 16'h0000);

        // Reset and idle
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        repeat (10) tick();
        check("reset_digit", 32'(bus.digit_out), 32'h0);
        check("reset_blank", 32'(bus.blank), 32'h1);

        // Auto rotation between sources 1 and 3
        put(1, 16'h1111);
        put(3, 16'h3333);
        bus.mode_auto = 1'b1;
        bus.req = 4'b1010;
        tick();
        check("auto_first_grant", 32'(bus.grant), 32'b0010);
        tick();
        check("auto_first_digit", 32'(bus.digit_out), 32'h1111);
        tick(); tick();
        check("auto_dwell_hold", 32'(bus.grant), 32'b0010);
        tick();
        check("auto_rotate_3", 32'(bus.grant), 32'b1000);
        repeat (4) tick();
        check("auto_rotate_1", 32'(bus.grant), 32'b0010);

        // Manual stepping across all sources
        rst = 1'b1; tick(); rst = 1'b0;
        bus.mode_auto = 1'b0;
        for (int i = 0; i < NSRC; i++) put(i, 16'(16'hA000 + i));
        bus.req = 4'b1111;
        tick();
        check("manual_first", 32'(bus.src_id), 32'd0);
        for (int p = 1; p <= 4; p++) begin
            repeat (9) tick();
            bus.step = 1'b1;
            tick();
            bus.step = 1'b0;
`ifdef DISP_ARB_PRIO_EN
            check("manual_step_prio", 32'(bus.src_id), 32'd0);
`else
            check("manual_step", 32'(bus.src_id), 32'(p % NSRC));
`endif
        end

        // Granted source drops its request
        rst = 1'b1; tick(); rst = 1'b0;
        put(2, 16'h2222);
        bus.req = 4'b0100;
        tick(); tick(); tick(); tick();
        bus.req = 4'b0000;
        tick();
        check("drop_blank", 32'(bus.blank), 32'h1);
        check("drop_grant", 32'(bus.grant), 32'h0);
        check("drop_digit_hold", 32'(bus.digit_out), 32'h2222);

        // Reset while showing source 3
        bus.req = 4'b1000;
        tick();
        check("pre_rst_src", 32'(bus.src_id), 32'd3);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("rst_abort_blank", 32'(bus.blank), 32'h1);
        rst = 1'b0;
        bus.req = 4'b1111;
        tick();
        check("post_rst_first", 32'(bus.src_id), 32'd0);

        // Source 0 pre-emption (explicit checks only in priority build)
        rst = 1'b1; tick(); rst = 1'b0;
        bus.req = 4'b0100;
        tick(); tick();
        bus.req = 4'b0111;
        tick();
`ifdef DISP_ARB_PRIO_EN
        check("prio_preempt", 32'(bus.src_id), 32'd0);
`endif
        for (int k = 0; k < 3; k++) begin
            bus.step = 1'b1; tick(); bus.step = 1'b0; tick();
`ifdef DISP_ARB_PRIO_EN
            check("prio_step_ignored", 32'(bus.src_id), 32'd0);
`endif
        end
        bus.req = 4'b0110;
        tick();
`ifdef DISP_ARB_PRIO_EN
        check("prio_resume", 32'(bus.src_id), 32'd1);
`endif

        // Randomised traffic
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(7) == 0) bus.req = 4'($urandom);
            bus.step = ($urandom_range(9) == 0);
            if ($urandom_range(49) == 0) bus.mode_auto = ~bus.mode_auto;
            put(int'($urandom_range(NSRC - 1)), 16'($urandom));
            rst = ($urandom_range(199) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_display_arbiter
`default_nettype wire
